pc_sequencer: RTL and testbench

Parametrised program-counter sequencer replacing the fixed PC register plus add-4 ALU loop in the processor top level. It holds the PC and computes the next PC from four sources: sequential, relative branch, absolute jump and trap vector. It drives a request/acknowledge fetch handshake toward instruction memory, and supports stall and redirect requests that arrive mid-fetch. It sits between the control state machine and the instruction fetch path.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_next_mux.sv | 53 +++++
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: next-PC source select,
// FSM state encoding and the pending-redirect record.
package pc_pkg;

  // Widest PC supported by the redirect record; instances use the low XLEN bits.
  localparam int unsigned PC_XLEN_MAX = 64;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    TRAP   = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pc_state_t;

  typedef struct packed {
    pc_sel_t                sel;
    logic [PC_XLEN_MAX-1:0] imm;
    logic [PC_XLEN_MAX-1:0] target;
  } redir_rec_t;

  // BRANCH and JUMP produce computed addresses that may be misaligned.
  function automatic logic is_xfer(input pc_sel_t sel);
    return (sel == BRANCH) || (sel == JUMP);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and fetch-handshake bundle between the control FSM, the PC
// sequencer and instruction memory.
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 64
);
  import pc_pkg::*;

  logic            stall;
  logic            redir;
  pc_sel_t         sel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;

  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_ack;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            misaligned;

  modport master (
    input  stall, redir, sel, imm, target, fetch_ack,
    output fetch_req, fetch_addr, pc, pc_plus, misaligned
  );

  modport slave (
    output stall, redir, sel, imm, target, fetch_ack,
    input  fetch_req, fetch_addr, pc, pc_plus, misaligned
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection and alignment screening.
// PC_ALIGN_CHECK_EN: misaligned BRANCH/JUMP results are replaced by TRAP_VECTOR.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     INC         = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h100)
) (
  input  logic [XLEN-1:0] pc,
  input  pc_sel_t         sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] next_pc,
  output logic            reject
);

  logic [XLEN-1:0] raw_pc;

  assign pc_plus = pc + XLEN'(INC);

  always_comb begin
    raw_pc = pc_plus;
    case (sel)
      SEQ:     raw_pc = pc_plus;
      BRANCH:  raw_pc = pc + imm;
      JUMP:    raw_pc = target;
      TRAP:    raw_pc = TRAP_VECTOR;
      default: raw_pc = pc_plus;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam int unsigned ALIGN_BITS = $clog2(INC);
  logic low_bits_nz;

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign low_bits_nz = |raw_pc[ALIGN_BITS-1:0];
    end else begin : g_byte_align
      assign low_bits_nz = 1'b0;
    end
  endgenerate

  assign reject  = is_xfer(sel) && low_bits_nz;
  assign next_pc = reject ? TRAP_VECTOR : raw_pc;
`else
  assign reject  = 1'b0;
  assign next_pc = raw_pc;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, drives the fetch handshake and
// applies direct or latched redirects. Optional macro: PC_ALIGN_CHECK_EN.
//
// state | meaning
// BOOT  | reset vector loaded, no request yet
// FETCH | fetch_req high, pc advances on an unstalled ack
// HOLD  | stalled, request withdrawn, pc frozen
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 64,
  parameter int unsigned     INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input  logic           CLK,
  input  logic           RST,
  pc_sequencer_if.master bus
);

  pc_state_t       state;
  pc_state_t       state_nxt;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] nxt_pc;
  logic            req_q;
  logic            mis_q;
  logic            pend_v;
  redir_rec_t      pend_rec;
  redir_rec_t      new_rec;
  redir_rec_t      use_rec;
  pc_sel_t         mux_sel;

  logic            accept;
  logic            capture;
  logic            reject;
  logic            req_nxt;
  logic            mis_nxt;

  always_comb begin
    new_rec        = '0;
    new_rec.sel    = bus.sel;
    new_rec.imm    = PC_XLEN_MAX'(bus.imm);
    new_rec.target = PC_XLEN_MAX'(bus.target);
  end

  // A redirect arriving now is newer than anything latched, so it wins.
  always_comb begin
    use_rec = bus.redir ? new_rec : pend_rec;
    mux_sel = (bus.redir || pend_v) ? use_rec.sel : SEQ;
  end

  pc_next_mux #(
    .XLEN        (XLEN),
    .INC         (INC),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_mux (
    .pc      (pc_q),
    .sel     (mux_sel),
    .imm     (use_rec.imm[XLEN-1:0]),
    .target  (use_rec.target[XLEN-1:0]),
    .pc_plus (pc_plus),
    .next_pc (nxt_pc),
    .reject  (reject)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= BOOT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (bus.stall)  state_nxt = HOLD;
      HOLD:    if (!bus.stall) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    accept  = (state == FETCH) && bus.fetch_ack && !bus.stall;
    capture = bus.redir && !accept;
    req_nxt = (state_nxt == FETCH);
    mis_nxt = accept && reject;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q     <= RESET_VECTOR;
      req_q    <= 1'b0;
      mis_q    <= 1'b0;
      pend_v   <= 1'b0;
      pend_rec <= '0;
    end else begin
      req_q <= req_nxt;
      mis_q <= mis_nxt;
      if (accept) pc_q <= nxt_pc;
      if (capture) begin
        pend_v   <= 1'b1;
        pend_rec <= new_rec;
      end else if (accept) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign bus.fetch_req  = req_q;
  assign bus.fetch_addr = pc_q;
  assign bus.pc         = pc_q;
  assign bus.pc_plus    = pc_plus;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed scenarios plus random
// stall/redirect/ack traffic against a transaction-level PC model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int unsigned INC    = 4;
  localparam logic [63:0] TRAP_V = 64'h100;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pc_sequencer_if #(.XLEN(64)) bus ();

  pc_sequencer #(
    .XLEN         (64),
    .INC          (INC),
    .RESET_VECTOR (64'h0),
    .TRAP_VECTOR  (TRAP_V)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  typedef struct {
    bit          req;
    logic [63:0] addr;
    bit          mis;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] imm;
    logic [63:0] tgt;
  } mrec_t;

  exp_t  exp_q[$];
  mrec_t m_pend[$];
  logic [63:0] m_pc;
  bit    m_req, m_boot, m_mis;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc   = 64'h0;
    m_req  = 1'b0;
    m_boot = 1'b1;
    m_mis  = 1'b0;
    m_pend.delete();
  endfunction

  // Where a fetch goes next given a source select, from the architectural rules.
  function automatic void resolve(input logic [1:0] s, input logic [63:0] im, input logic [63:0] tg,
                                  output logic [63:0] npc, output bit bad);
    bad = 1'b0;
    case (s)
      2'd0:    npc = m_pc + 64'(INC);
      2'd1:    npc = m_pc + im;
      2'd2:    npc = tg;
      default: npc = TRAP_V;
    endcase
    if (ALIGN_EN && (s == 2'd1 || s == 2'd2) && (npc % 64'(INC)) != 0) begin
      bad = 1'b1;
      npc = TRAP_V;
    end
  endfunction

  function automatic void model_step(input bit st, input bit rd, input logic [1:0] s,
                                     input logic [63:0] im, input logic [63:0] tg, input bit ak);
    mrec_t r;
    logic [63:0] npc;
    bit bad;
    bit accept;
    r.sel = s; r.imm = im; r.tgt = tg;
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
      if (rd) begin m_pend.delete(); m_pend.push_back(r); end
      return;
    end
    accept = m_req && ak && !st;
    if (accept) begin
      if (rd)                     resolve(s, im, tg, npc, bad);
      else if (m_pend.size() > 0) resolve(m_pend[0].sel, m_pend[0].imm, m_pend[0].tgt, npc, bad);
      else                        resolve(2'd0, im, tg, npc, bad);
      m_pc  = npc;
      m_mis = bad;
      m_pend.delete();
    end else if (rd) begin
      m_pend.delete();
      m_pend.push_back(r);
    end
    m_req = !st;
  endfunction

  task automatic drive(input bit st, input bit rd, input logic [1:0] s,
                       input logic [63:0] im, input logic [63:0] tg, input bit ak);
    exp_t e;
    bus.stall     = st;
    bus.redir     = rd;
    bus.sel       = pc_sel_t'(s);
    bus.imm       = im;
    bus.target    = tg;
    bus.fetch_ack = ak;
    model_step(st, rd, s, im, tg, ak);
    e.req = m_req; e.addr = m_pc; e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit rd, input logic [1:0] s,
                     input logic [63:0] im, input logic [63:0] tg, input bit ak);
    @(negedge CLK);
    drive(st, rd, s, im, tg, ak);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  // Scoreboard: one expectation per clock edge that stimulus was issued for.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_req",     64'(bus.fetch_req),  64'(e.req));
        chk("sb_addr",    bus.fetch_addr,      e.addr);
        chk("sb_pc",      bus.pc,              e.addr);
        chk("sb_pc_plus", bus.pc_plus,         e.addr + 64'(INC));
        chk("sb_mis",     64'(bus.misaligned), 64'(e.mis));
      end
    end
  end

  initial begin
    logic [63:0] exp_align_pc;
    logic [31:0] r;
    logic [63:0] im, tg;
    RST = 1'b0;
    bus.stall = 1'b0; bus.redir = 1'b0; bus.sel = SEQ;
    bus.imm = '0; bus.target = '0; bus.fetch_ack = 1'b0;
    model_reset();

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pc",  bus.pc,                 64'h0);
    chk("rst_req", 64'(bus.fetch_req),     64'h0);
    chk("rst_mis", 64'(bus.misaligned),    64'h0);

    @(negedge CLK);
    RST = 1'b1;
    drive(0, 0, 2'd0, 0, 0, 1);
    settle();
    chk("boot_req",  64'(bus.fetch_req), 64'h1);
    chk("boot_addr", bus.fetch_addr,     64'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 2'd0, 0, 0, 1);
      settle();
      chk("seq_addr", bus.fetch_addr, 64'(4 * i));
    end

    cyc(0, 1, 2'd2, 0, 64'h40, 1);
    settle();
    chk("jump_direct", bus.fetch_addr, 64'h40);

    cyc(0, 1, 2'd1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0);
    settle(); chk("br_hold0", bus.fetch_addr, 64'h40);
    cyc(0, 0, 2'd0, 0, 0, 0);
    settle(); chk("br_hold1", bus.fetch_addr, 64'h40);
    cyc(0, 0, 2'd0, 0, 0, 0);
    settle(); chk("br_hold2", bus.fetch_addr, 64'h40);
    chk("br_req_held", 64'(bus.fetch_req), 64'h1);
    cyc(0, 0, 2'd0, 0, 0, 1);
    settle(); chk("br_taken", bus.fetch_addr, 64'h30);

    cyc(0, 1, 2'd2, 0, 64'h200, 0);
    cyc(0, 1, 2'd3, 0, 0, 0);
    cyc(0, 0, 2'd0, 0, 0, 1);
    settle(); chk("trap_overwrite", bus.pc, 64'h100);

    cyc(0, 1, 2'd2, 0, 64'h80, 1);
    cyc(1, 0, 2'd0, 0, 0, 1);
    settle();
    chk("stall_pc",  bus.pc,             64'h80);
    chk("stall_req", 64'(bus.fetch_req), 64'h0);
    cyc(0, 0, 2'd0, 0, 0, 0);
    settle();
    chk("unstall_req",  64'(bus.fetch_req), 64'h1);
    chk("unstall_addr", bus.fetch_addr,     64'h80);
    cyc(0, 0, 2'd0, 0, 0, 1);
    settle(); chk("unstall_seq", bus.fetch_addr, 64'h84);

    cyc(0, 1, 2'd2, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    settle(); chk("wrap_plus", bus.pc_plus, 64'h0);
    cyc(0, 0, 2'd0, 0, 0, 1);
    settle(); chk("wrap_pc", bus.pc, 64'h0);

    exp_align_pc = ALIGN_EN ? 64'h100 : 64'h202;
    cyc(0, 1, 2'd2, 0, 64'h202, 1);
    settle();
    chk("align_pc",  bus.pc,              exp_align_pc);
    chk("align_mis", 64'(bus.misaligned), 64'(ALIGN_EN));
    cyc(0, 0, 2'd0, 0, 0, 0);
    settle(); chk("align_mis_end", 64'(bus.misaligned), 64'h0);

    // Asynchronous reset with a request outstanding and a redirect latched.
    cyc(0, 1, 2'd2, 0, 64'h500, 0);
    settle();
    #1 RST = 1'b0;
    #1;
    chk("arst_req", 64'(bus.fetch_req), 64'h0);
    chk("arst_pc",  bus.pc,             64'h0);
    model_reset();
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    drive(0, 0, 2'd0, 0, 0, 1);
    settle(); chk("arst_boot", bus.fetch_addr, 64'h0);
    cyc(0, 0, 2'd0, 0, 0, 1);
    settle(); chk("arst_no_pend", bus.fetch_addr, 64'h4);

    for (int n = 0; n < 3000; n++) begin
      r  = $urandom;
      im = {{32{r[31]}}, r};
      tg = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) begin
        im[1:0] = 2'b00;
        tg[1:0] = 2'b00;
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          2'($urandom_range(0, 3)), im, tg, $urandom_range(0, 9) < 6);
    end
    cyc(0, 0, 2'd0, 0, 0, 0);
    repeat (3) @(posedge CLK);
    #2;
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
